dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Arbiter and sequencer for the single-ported 16-bit data memory shared by the multicycle core's load/store path (requester 0) and a debug/loader port (requester 1). It accepts one request at a time with a valid/ready handshake and drives the memory port for exactly one cycle. It waits a fixed memory latency and returns read data, or a write ack, to the granted requester. Out-of-range addresses are rejected without touching memory.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_DEPTH, 65536, number of valid words; addr >= MEM_DEPTH is out of range
MEM_LAT, 1, cycles from the mem_en cycle to mem_rdata valid (legal 1..7)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 request valid
req0_ready  out  1  requester 0 accepted this cycle
req0_we  in  1  1=write, 0=read
req0_addr  in  ADDR_W  word address
req0_wdata  in  DATA_W  write data
rsp0_valid  out  1  one-cycle response pulse
rsp0_rdata  out  DATA_W  read data; 0 for writes and errors
rsp0_err  out  1  out-of-range flag, qualified by rsp0_valid
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err  same as requester 0
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in every state except IDLE
grant_id  out  1  requester currently or most recently granted

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Latency counter is 3 bits.
- Reset, asynchronous: state=IDLE, last_grant=1, counter=0. All registered outputs go to 0: mem_*, rsp*_*, busy, grant_id. An in-flight transaction is dropped and produces no response.
- req*_ready is combinational. It is high only in IDLE, for the selected requester, and only while that requester's valid is high. The handshake completes on the clock edge where valid&&ready.
- Selection in IDLE: if only one valid is high, grant it. If both are high, grant !last_grant (round-robin). On grant, latch we/addr/wdata/id and set last_grant=grant_id=id.
- Requesters hold valid and fields stable until ready. A valid dropped before ready is ignored with no side effect.
- IDLE -> ACCESS on grant when addr < MEM_DEPTH.
- IDLE -> RESP on grant when addr >= MEM_DEPTH. The error response pulses in the next cycle with err=1, rdata=0, and no mem_en.
- ACCESS, one cycle: mem_en=1, mem_we/addr/wdata = latched values; counter loads MEM_LAT. Next state is WAIT.
- WAIT: mem_en=0; counter decrements each cycle. When counter reaches 1, sample mem_rdata (reads) and move to RESP. mem_rdata is therefore sampled exactly MEM_LAT cycles after the ACCESS cycle.
- RESP, one cycle: rsp<id>_valid=1 with registered rdata (0 for writes) and err. The other requester's rsp outputs stay 0. Next state is IDLE. rsp*_rdata and err return to 0 when valid is low.
- Timing for a grant at edge T: mem_en in cycle T+1, rsp_valid in cycle T+2+MEM_LAT. The next grant is possible in cycle T+3+MEM_LAT.
- A requester may present a new request in the RESP cycle. It is accepted in the following IDLE cycle.
- Both requesters continuously valid: grants strictly alternate 0,1,0,1...

Optional Feature:
DMEM_ARB_FIXED_PRIO_EN. When defined, requester 0 always wins a tie and last_grant is ignored for selection; grant_id still updates. Requester 1 may starve; this mode is intended for core-only bring-up. When undefined, round-robin is used as above.

Test Plan:
1. Assert reset for 2 cycles, then release with no requests -> all outputs 0, busy=0, ready0=ready1=0.
2. MEM_LAT=1; model returns 0x01A4 at addr 0. req0 read addr 0x0000 at cycle 0 -> ready0=1 in cycle 0; cycle 1: mem_en=1, mem_we=0, mem_addr=0x0000; cycle 3: rsp0_valid=1, rsp0_rdata=0x01A4, err=0.
3. req0 and req1 both held valid from reset (reads at 0x0001 and 0x0002) -> grant order 0,1,0,1. Each grant occurs 4 cycles after the previous one; rsp1_valid is never asserted for a requester-0 transaction.
4. req1 write addr 0x0010 data 0x00FF -> mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x00FF for exactly one cycle; rsp1_valid=1, rsp1_rdata=0x0000, err=0.
5. MEM_DEPTH=256; req0 read addr 0x0100 -> mem_en never asserts; rsp0_valid=1 with rsp0_err=1 and rsp0_rdata=0 one cycle after the grant.
6. MEM_LAT=3; assert reset during WAIT -> mem_en=0 and no rsp pulse. After release, a req1 read at 0x0005 completes normally with rsp1_valid 5 cycles after the grant.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: one requester's view of the shared data-memory port.
// The requester drives valid/we/addr/wdata and receives ready plus a one-cycle
// response (rsp_valid, rsp_rdata, rsp_err). The arbiter uses the slave modport.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-ported data memory between the core's
// load/store path (requester 0) and a debug/loader port (requester 1).
// One transaction at a time: IDLE -> ACCESS -> WAIT -> RESP, or IDLE -> RESP
// for an out-of-range address (no memory access, error response).
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins a tie
// instead of round-robin; requester 1 can starve (core-only bring-up).
module dmem_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 65536,
    parameter int MEM_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    dmem_port_arbiter_if.slave  req0,
    dmem_port_arbiter_if.slave  req1,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_W (every address valid) is representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [2:0]      LAT_LOAD  = 3'(MEM_LAT);

    state_t                  state;
    logic                    last_grant;
    logic [2:0]              lat_cnt;
    logic                    op_we;
    logic [1:0]              rsp_valid_q;
    logic [1:0]              rsp_err_q;
    logic [1:0][DATA_W-1:0]  rsp_rdata_q;

    logic                    tie_id;
    logic                    sel_id;
    logic                    sel_any;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic                    grant;
    logic                    in_range;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign tie_id = 1'b0;
`else
    assign tie_id = ~last_grant;
`endif

    // Choose which requester would be granted this cycle and mux its fields.
    always_comb begin
        sel_any = req0.valid | req1.valid;
        if (req0.valid && req1.valid) begin
            sel_id = tie_id;
        end else begin
            sel_id = req1.valid;
        end
        sel_we    = sel_id ? req1.we    : req0.we;
        sel_addr  = sel_id ? req1.addr  : req0.addr;
        sel_wdata = sel_id ? req1.wdata : req0.wdata;
        grant     = (state == S_IDLE) && sel_any;
        in_range  = {1'b0, sel_addr} < DEPTH_LIM;
    end

    // Ready only for the selected requester while it is presenting a request.
    assign req0.ready = grant && !sel_id;
    assign req1.ready = grant &&  sel_id;

    assign req0.rsp_valid = rsp_valid_q[0];
    assign req0.rsp_rdata = rsp_rdata_q[0];
    assign req0.rsp_err   = rsp_err_q[0];
    assign req1.rsp_valid = rsp_valid_q[1];
    assign req1.rsp_rdata = rsp_rdata_q[1];
    assign req1.rsp_err   = rsp_err_q[1];

    // Transaction sequencer; every output is registered and pulses for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            lat_cnt     <= 3'd0;
            op_we       <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_rdata_q <= '0;
            busy        <= 1'b0;
            grant_id    <= 1'b0;
        end else begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_rdata_q <= '0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        last_grant <= sel_id;
                        grant_id   <= sel_id;
                        op_we      <= sel_we;
                        busy       <= 1'b1;
                        if (in_range) begin
                            state     <= S_ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end else begin
                            // Rejected: answer next cycle without touching memory.
                            state               <= S_RESP;
                            rsp_valid_q[sel_id] <= 1'b1;
                            rsp_err_q[sel_id]   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        state                 <= S_RESP;
                        rsp_valid_q[grant_id] <= 1'b1;
                        rsp_rdata_q[grant_id] <= op_we ? '0 : mem_rdata;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed bench for dmem_port_arbiter.
// dut_a: MEM_LAT=1, MEM_DEPTH=256; dut_b: MEM_LAT=3, full address range.
// Memory models return data only in the exact cycle the arbiter must sample.
module tb_dmem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct packed {
        logic        v;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
    } rq_t;

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic        men;
        logic        mwe;
        logic [15:0] maddr;
        logic [15:0] mwd;
        logic        rv0;
        logic [15:0] rd0;
        logic        re0;
        logic        rv1;
        logic [15:0] rd1;
        logic        re1;
        logic        busy;
        logic        gid;
    } ex_t;

    typedef struct {
        rq_t r0;
        rq_t r1;
        ex_t ex;
    } vec_t;

    logic        clk;
    logic        reset_a;
    logic        reset_b;
    logic        mem_en_a, mem_we_a, busy_a, grant_id_a;
    logic [15:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic        mem_en_b, mem_we_b, busy_b, grant_id_b;
    logic [15:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [2:0]  lc_a, lc_b;
    logic [15:0] aq_a, aq_b;

    int errors = 0;
    int checks = 0;

    dmem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) r0a ();
    dmem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) r1a ();
    dmem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) r0b ();
    dmem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) r1b ();

    dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(256), .MEM_LAT(LAT_A)) dut_a (
        .clk(clk), .reset(reset_a), .req0(r0a), .req1(r1a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .grant_id(grant_id_a)
    );

    dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(65536), .MEM_LAT(LAT_B)) dut_b (
        .clk(clk), .reset(reset_b), .req0(r0b), .req1(r1b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .grant_id(grant_id_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [15:0] a);
        return 16'h01A4 ^ (a << 4);
    endfunction

    // Memory models: data appears only in cycle (mem_en cycle + LAT), else junk.
    always @(posedge clk or posedge reset_a) begin
        if (reset_a) lc_a <= 3'd0;
        else if (mem_en_a) begin lc_a <= 3'd1; aq_a <= mem_addr_a; end
        else if (lc_a == 3'(LAT_A)) lc_a <= 3'd0;
        else if (lc_a != 3'd0) lc_a <= lc_a + 3'd1;
    end
    assign mem_rdata_a = (lc_a == 3'(LAT_A)) ? model(aq_a) : 16'hBAD0;

    always @(posedge clk or posedge reset_b) begin
        if (reset_b) lc_b <= 3'd0;
        else if (mem_en_b) begin lc_b <= 3'd1; aq_b <= mem_addr_b; end
        else if (lc_b == 3'(LAT_B)) lc_b <= 3'd0;
        else if (lc_b != 3'd0) lc_b <= lc_b + 3'd1;
    end
    assign mem_rdata_b = (lc_b == 3'(LAT_B)) ? model(aq_b) : 16'hBAD0;

    function automatic rq_t rq(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d);
        return {v, we, a, d};
    endfunction

    function automatic ex_t ex(input logic r0, input logic r1, input logic men, input logic mwe,
                               input logic [15:0] ma, input logic [15:0] md,
                               input logic rv0, input logic [15:0] rd0, input logic re0,
                               input logic rv1, input logic [15:0] rd1, input logic re1,
                               input logic b, input logic g);
        return {r0, r1, men, mwe, ma, md, rv0, rd0, re0, rv1, rd1, re1, b, g};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_a(input rq_t a, input rq_t b);
        r0a.valid = a.v; r0a.we = a.we; r0a.addr = a.a; r0a.wdata = a.d;
        r1a.valid = b.v; r1a.we = b.we; r1a.addr = b.a; r1a.wdata = b.d;
    endtask

    task automatic drive_b(input rq_t a, input rq_t b);
        r0b.valid = a.v; r0b.we = a.we; r0b.addr = a.a; r0b.wdata = a.d;
        r1b.valid = b.v; r1b.we = b.we; r1b.addr = b.a; r1b.wdata = b.d;
    endtask

    vec_t tbl[23];
    rq_t  nr;
    ex_t  act;
    ex_t  e;
    logic e_r0, e_r1, e_v0, e_v1, e_men, e_b;

    initial begin
        nr = rq(1'b0, 1'b0, 16'h0, 16'h0);
        // cycle-by-cycle table for dut_a (MEM_LAT=1, MEM_DEPTH=256)
        tbl[0]  = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,0)};
        tbl[1]  = '{rq(1,0,16'h0000,16'h0), nr, ex(1,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,0)};
        tbl[2]  = '{nr, nr, ex(0,0, 1,0,16'h0000,16'h0, 0,16'h0,0, 0,16'h0,0, 1,0)};
        tbl[3]  = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 1,0)};
        tbl[4]  = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 1,16'h01A4,0, 0,16'h0,0, 1,0)};
        tbl[5]  = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,0)};
        tbl[6]  = '{nr, rq(1,1,16'h0010,16'h00FF), ex(0,1, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,0)};
        tbl[7]  = '{nr, nr, ex(0,0, 1,1,16'h0010,16'h00FF, 0,16'h0,0, 0,16'h0,0, 1,1)};
        tbl[8]  = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 1,1)};
        tbl[9]  = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 1,16'h0000,0, 1,1)};
        tbl[10] = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,1)};
        tbl[11] = '{rq(1,0,16'h0100,16'h0), nr, ex(1,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,1)};
        tbl[12] = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 1,16'h0000,1, 0,16'h0,0, 1,0)};
        tbl[13] = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,0)};
        tbl[14] = '{rq(1,0,16'h00FF,16'h0), nr, ex(1,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,0)};
        tbl[15] = '{nr, nr, ex(0,0, 1,0,16'h00FF,16'h0, 0,16'h0,0, 0,16'h0,0, 1,0)};
        tbl[16] = '{rq(1,0,16'h0003,16'h0), nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 1,0)};
        tbl[17] = '{nr, rq(1,0,16'h0002,16'h0), ex(0,0, 0,0,16'h0,16'h0, 1,16'h0E54,0, 0,16'h0,0, 1,0)};
        tbl[18] = '{nr, rq(1,0,16'h0002,16'h0), ex(0,1, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,0)};
        tbl[19] = '{nr, nr, ex(0,0, 1,0,16'h0002,16'h0, 0,16'h0,0, 0,16'h0,0, 1,1)};
        tbl[20] = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 1,1)};
        tbl[21] = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 1,16'h0184,0, 1,1)};
        tbl[22] = '{nr, nr, ex(0,0, 0,0,16'h0,16'h0, 0,16'h0,0, 0,16'h0,0, 0,1)};

        reset_a = 1'b1;
        reset_b = 1'b1;
        drive_a(nr, nr);
        drive_b(nr, nr);
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive_a(tbl[i].r0, tbl[i].r1);
            #1;
            act = {r0a.ready, r1a.ready, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a,
                   r0a.rsp_valid, r0a.rsp_rdata, r0a.rsp_err,
                   r1a.rsp_valid, r1a.rsp_rdata, r1a.rsp_err, busy_a, grant_id_a};
            if (!tbl[i].ex.men) begin
                act.mwe = 1'b0; act.maddr = 16'h0; act.mwd = 16'h0;
            end
            check($sformatf("vec%0d", i), 128'(act), 128'(tbl[i].ex));
            if (i == 0) begin
                check("reset_b_idle",
                      128'({r0b.ready, r1b.ready, mem_en_b, r0b.rsp_valid, r1b.rsp_valid, busy_b, grant_id_b}),
                      128'(7'b0));
            end
        end

        // Both requesters held valid from reset: grants alternate every 4 cycles.
        @(negedge clk);
        reset_a = 1'b1;
        drive_a(rq(1,0,16'h0001,16'h0), rq(1,0,16'h0002,16'h0));
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) reset_a = 1'b0;
            #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            e_r0 = (c % 4 == 0); e_r1 = 1'b0; e_v0 = (c % 4 == 3); e_v1 = 1'b0;
`else
            e_r0 = (c % 8 == 0); e_r1 = (c % 8 == 4); e_v0 = (c % 8 == 3); e_v1 = (c % 8 == 7);
`endif
            check($sformatf("rr_cyc%0d", c),
                  128'({r0a.ready, r1a.ready, r0a.rsp_valid, r0a.rsp_rdata, r1a.rsp_valid, r1a.rsp_rdata}),
                  128'({e_r0, e_r1, e_v0, e_v0 ? 16'h01B4 : 16'h0, e_v1, e_v1 ? 16'h0184 : 16'h0}));
        end
        @(negedge clk);
        drive_a(nr, nr);

        // dut_b (MEM_LAT=3): reset during WAIT drops the transaction.
        @(negedge clk);
        drive_b(rq(1,0,16'h0003,16'h0), nr);
        #1;
        check("b_grant0", 128'({r0b.ready, busy_b}), 128'(2'b10));
        @(negedge clk);
        drive_b(nr, nr);
        #1;
        check("b_access", 128'({mem_en_b, mem_addr_b, busy_b}), 128'({1'b1, 16'h0003, 1'b1}));
        @(negedge clk);
        #1;
        check("b_wait", 128'({mem_en_b, busy_b}), 128'(2'b01));
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) reset_b = 1'b1;
            if (c == 2) reset_b = 1'b0;
            #1;
            check($sformatf("b_drop%0d", c),
                  128'({mem_en_b, busy_b, r0b.rsp_valid, r1b.rsp_valid, r0b.rsp_err, grant_id_b}),
                  128'(6'b0));
        end

        // After reset release, a req1 read completes with rsp 5 cycles after grant.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            drive_b(nr, (c == 0) ? rq(1,0,16'h0005,16'h0) : nr);
            #1;
            e_r1  = (c == 0);
            e_men = (c == 1);
            e_v1  = (c == 5);
            e_b   = (c >= 1 && c <= 5);
            check($sformatf("b_req1_cyc%0d", c),
                  128'({r1b.ready, mem_en_b, mem_en_b ? mem_addr_b : 16'h0, r1b.rsp_valid, r1b.rsp_rdata,
                        r1b.rsp_err, r0b.rsp_valid, busy_b}),
                  128'({e_r1, e_men, e_men ? 16'h0005 : 16'h0, e_v1, e_v1 ? 16'h01F4 : 16'h0,
                        1'b0, 1'b0, e_b}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
